// File: rtl/pattern_pkg.sv
// Shared definitions for the walking-one-with-marker pattern (generator and checker).
// Expectation position is a phase bit plus shift index k in 1..7.
package pattern_pkg;

    localparam logic [7:0] PAT_MARKER = 8'h01;
    localparam int         PAT_PERIOD = 14;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    // phase 0: marker expected; phase 1: shift word 1<<k expected
    typedef struct packed {
        logic       phase;
        logic [2:0] k;
    } exp_pos_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] k;
    } seed_t;

    function automatic exp_pos_t next_expected(input exp_pos_t cur);
        exp_pos_t nxt;
        nxt.phase = ~cur.phase;
        if (cur.phase)
            nxt.k = (cur.k == 3'd7) ? 3'd1 : cur.k + 3'd1;
        else
            nxt.k = cur.k;
        return nxt;
    endfunction

    function automatic logic [7:0] exp_word(input exp_pos_t cur);
        return cur.phase ? (8'h01 << cur.k) : PAT_MARKER;
    endfunction

    // 0x01 is ambiguous, so only 0x02..0x80 one-hot words can seed
    function automatic seed_t seed_decode(input logic [7:0] w);
        seed_t s;
        s.hit = 1'b0;
        s.k   = 3'd1;
        for (int i = 1; i < 8; i++) begin
            if (w == (8'h01 << i)) begin
                s.hit = 1'b1;
                s.k   = 3'(i);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/pattern_expect_gen.sv
// Holds the expected-word position; seeds, advances on enable, and drives exp_data (0x00 when inactive).
// exp_data follows the registered position with no combinational input path; never stalls.
module pattern_expect_gen
    import pattern_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       seed_en,
    input  logic [2:0] seed_k,
    input  logic       adv_en,
    input  logic       clr_en,
    output logic [7:0] exp_data
);

    exp_pos_t pos_q;
    logic     active_q;
    exp_pos_t seed_pos;

    assign seed_pos = '{phase: 1'b1, k: seed_k};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_q    <= '{phase: 1'b0, k: 3'd1};
            active_q <= 1'b0;
        end else if (clr_en) begin
            active_q <= 1'b0;
        end else if (seed_en) begin
            // the seed word itself was just consumed, so start one step beyond it
            active_q <= 1'b1;
            pos_q    <= next_expected(seed_pos);
        end else if (adv_en) begin
            pos_q    <= next_expected(pos_q);
        end
    end

    assign exp_data = active_q ? exp_word(pos_q) : 8'h00;

endmodule

// File: rtl/pattern_checker.sv
// Receive checker for the 14-word walking-one stream: hunt, sync, lock, flywheel, count errors.
// Outputs registered, 1-cycle latency; in_valid=0 holds everything. Optional err_sticky/err_clr under PATTERN_CHECKER_STICKY_EN.
module pattern_checker
    import pattern_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       exp_data
`ifdef PATTERN_CHECKER_STICKY_EN
    ,
    input  logic             err_clr,
    output logic             err_sticky
`endif
);

    localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CNT);

    chk_state_t       state_q, state_d;
    logic [3:0]       match_q, match_d;
    logic [3:0]       miss_q, miss_d;
    logic             err_hit;
    logic             seed_en, adv_en, clr_en;
    logic             word_ok;
    logic             err_pulse_q;
    logic [ERR_W-1:0] err_count_q;
    seed_t            seed;

    assign seed    = seed_decode(in_data);
    assign word_ok = (in_data == exp_data);

    pattern_expect_gen u_expect (
        .clk      (clk),
        .reset    (reset),
        .seed_en  (seed_en),
        .seed_k   (seed.k),
        .adv_en   (adv_en),
        .clr_en   (clr_en),
        .exp_data (exp_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= HUNT;
            match_q     <= 4'd0;
            miss_q      <= 4'd0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            err_pulse_q <= err_hit;
            if (err_hit && (err_count_q != '1))
                err_count_q <= err_count_q + ERR_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_hit = 1'b0;
        seed_en = 1'b0;
        adv_en  = 1'b0;
        clr_en  = 1'b0;
        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (seed.hit) begin
                        state_d = SYNC;
                        match_d = 4'd1;
                        seed_en = 1'b1;
                    end
                end
                SYNC: begin
                    if (word_ok) begin
                        match_d = match_q + 4'd1;
                        adv_en  = 1'b1;
                        if (match_q + 4'd1 == LOCK_N) begin
                            state_d = LOCKED;
                            miss_d  = 4'd0;
                        end
                    end else if (seed.hit) begin
                        // a mismatching word may still be a valid new seed
                        match_d = 4'd1;
                        seed_en = 1'b1;
                    end else begin
                        state_d = HUNT;
                        match_d = 4'd0;
                        clr_en  = 1'b1;
                    end
                end
                LOCKED: begin
                    adv_en = 1'b1;
                    if (word_ok) begin
                        miss_d = 4'd0;
                    end else begin
                        err_hit = 1'b1;
                        miss_d  = miss_q + 4'd1;
                        if (miss_q + 4'd1 == UNLOCK_N) begin
                            state_d = HUNT;
                            match_d = 4'd0;
                            miss_d  = 4'd0;
                            clr_en  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                    clr_en  = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        locked    = (state_q == LOCKED);
        err_pulse = err_pulse_q;
        err_count = err_count_q;
    end

`ifdef PATTERN_CHECKER_STICKY_EN
    logic sticky_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sticky_q <= 1'b0;
        else if (err_hit)
            sticky_q <= 1'b1;
        else if (err_clr)
            sticky_q <= 1'b0;
    end

    assign err_sticky = sticky_q;
`endif

endmodule
